// File: rtl/clk_period_meter.sv
`timescale 1ns/1ps
// clk_period_meter
//
// Measures the rising-to-rising period of a slow asynchronous signal in reference-clock
// cycles and hands the result to a consumer over a valid/ready handshake. Optionally also
// measures how many of those cycles the signal was high (duty cycle).
//
// Optional feature macro: CLK_PERIOD_METER_DUTY_EN
//   defined   - high-time counter present, high_o reports the high time.
//   undefined - no high-time counter, high_o is tied to 0.
//
// Parameters:
//   CNT_WIDTH   - width of the period/high-time counters and results.
//   SYNC_STAGES - flops in the sig_i synchronizer (minimum 2).
//
// Ports:
//   clk_i      - reference clock; all logic on its rising edge.
//   srst_i     - synchronous active-high reset.
//   sig_i      - asynchronous signal to measure.
//   start_i    - request one measurement; only sampled while idle.
//   busy_o     - a measurement is armed, running or waiting to be accepted.
//   period_o   - measured period in clk_i cycles.
//   high_o     - clk_i cycles the signal was high within that period.
//   overflow_o - measurement timed out; qualified by valid_o.
//   valid_o    - result available; held until accepted.
//   ready_i    - consumer accepts the result when valid_o && ready_i.
module clk_period_meter #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 sig_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 overflow_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    // ARM times out on the cycle its counter would reach all-ones.
    localparam logic [CNT_WIDTH-1:0] ArmLast = CntMax - CntOne;

    typedef enum logic [1:0] {StIdle, StArm, StMeasure, StDone} state_e;

    // ------------------------------------------------------------------
    // Synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_s;
    logic                   sig_q;
    logic                   rise;

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync_q <= '0;
            sig_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            sig_q  <= sig_s;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and period counter
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic                 ovf_q, ovf_d;
    logic                 arm_timeout;
    logic                 meas_timeout;

    assign arm_timeout  = (state_q == StArm) && !rise && (cnt_q == ArmLast);
    assign meas_timeout = (state_q == StMeasure) && !rise && (cnt_q == CntMax);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StArm;
                    cnt_d   = '0;
                end
            end
            StArm: begin
                if (rise) begin
                    state_d = StMeasure;
                    cnt_d   = CntOne;
                end else if (arm_timeout) begin
                    state_d  = StDone;
                    cnt_d    = CntMax;
                    period_d = CntMax;
                    ovf_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StMeasure: begin
                if (rise) begin
                    state_d  = StDone;
                    period_d = cnt_q;
                    ovf_d    = 1'b0;
                end else if (meas_timeout) begin
                    state_d  = StDone;
                    period_d = CntMax;
                    ovf_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StDone: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign valid_o    = (state_q == StDone);
    assign period_o   = period_q;
    assign overflow_o = ovf_q;

    // ------------------------------------------------------------------
    // Optional high-time counter
    // ------------------------------------------------------------------
`ifdef CLK_PERIOD_METER_DUTY_EN
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;

    // hcnt never exceeds cnt, so saturation of cnt bounds it too.
    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    hcnt_d = '0;
                end
            end
            StArm: begin
                if (rise) begin
                    hcnt_d = CntOne;
                end else if (arm_timeout) begin
                    high_d = '0;
                end
            end
            StMeasure: begin
                if (rise || meas_timeout) begin
                    high_d = hcnt_q;
                end else begin
                    hcnt_d = hcnt_q + {{(CNT_WIDTH-1){1'b0}}, sig_s};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_o = high_q;
`else
    assign high_o = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
module tb_clk_period_meter;

    localparam int unsigned W = 8;
`ifdef CLK_PERIOD_METER_DUTY_EN
    localparam bit Duty = 1'b1;
`else
    localparam bit Duty = 1'b0;
`endif

    logic         clk;
    logic         srst;
    logic         sig;
    logic         start;
    logic         ready;
    logic         busy;
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         ovf;
    logic         valid;

    clk_period_meter #(
        .CNT_WIDTH  (W),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i     (clk),
        .srst_i    (srst),
        .sig_i     (sig),
        .start_i   (start),
        .busy_o    (busy),
        .period_o  (period),
        .high_o    (high),
        .overflow_o(ovf),
        .valid_o   (valid),
        .ready_i   (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard entry: accepted period range, optional high-time check, overflow flag.
    typedef struct {
        int unsigned p_lo;
        int unsigned p_hi;
        int unsigned h;
        bit          chk_h;
        bit          o;
        int          tag;
    } exp_t;

    typedef struct {
        int unsigned n;
        int unsigned exp_p;
        int unsigned exp_h;
    } vec_t;

    exp_t sb_q[$];
    exp_t e;
    vec_t tbl[12];
    int   n_vec = 0;
    int   n_err = 0;

    // sig source: 0 = constant lvl, 1 = clk-synchronous divider, 2 = free-running async.
    int   mode  = 1;
    bit   lvl   = 1'b0;
    int   div_n = 4;
    int   phase = 0;

    initial begin
        sig = 1'b0;
        forever begin
            if (mode == 2) begin
                #36.65 sig = ~sig;
            end else begin
                @(negedge clk);
                if (mode == 1) begin
                    sig   = (phase < div_n / 2);
                    phase = (phase + 1 >= div_n) ? 0 : phase + 1;
                end else begin
                    sig = lvl;
                end
            end
        end
    end

    // Result checker: pops on every accepted handshake.
    always @(negedge clk) begin
        if (!srst && valid && ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got period=%0d ovf=%0b, required no result",
                         period, ovf);
            end else begin
                e = sb_q.pop_front();
                if (period < e.p_lo || period > e.p_hi || ovf != e.o ||
                    (e.chk_h && high != e.h)) begin
                    n_err++;
                    $display({"FAIL result[%0d]: got period=%0d high=%0d ovf=%0b, ",
                              "required period=%0d..%0d high=%0d ovf=%0b"},
                             e.tag, period, high, ovf, e.p_lo, e.p_hi, e.h, e.o);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic push(input int unsigned lo, input int unsigned hi, input int unsigned h,
                        input bit chk_h, input bit o, input int tag);
        exp_t x;
        x.p_lo  = lo;
        x.p_hi  = hi;
        x.h     = h;
        x.chk_h = chk_h;
        x.o     = o;
        x.tag   = tag;
        sb_q.push_back(x);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain(input int bound, input int tag);
        int k = 0;
        while (sb_q.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout[%0d]: %0d results outstanding after %0d cycles, required 0",
                     tag, sb_q.size(), bound);
            sb_q.delete();
        end
    endtask

    initial begin
        int k;
        srst  = 1'b1;
        start = 1'b0;
        ready = 1'b1;

        // Reset with sig toggling.
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_valid", valid, 0);
            check("rst_busy", busy, 0);
            check("rst_period", period, 0);
            check("rst_high", high, 0);
        end
        tick();
        srst = 1'b0;

        // Synchronous sweep N = 4..15.
        for (int i = 0; i < 12; i++) begin
            tbl[i].n     = 4 + i;
            tbl[i].exp_p = 4 + i;
            tbl[i].exp_h = Duty ? (4 + i) / 2 : 0;
        end
        for (int i = 0; i < 12; i++) begin
            div_n = tbl[i].n;
            phase = 0;
            ticks(2 * tbl[i].n);
            push(tbl[i].exp_p, tbl[i].exp_p, tbl[i].exp_h, 1'b1, 1'b0, i);
            pulse_start();
            wait_drain(4 * tbl[i].n + 20, i);
            @(negedge clk);
            check("valid_one_cycle", valid, 0);
            check("busy_with_valid", busy, 0);
            tick();
        end

        // Backpressure, N = 6.
        div_n = 6;
        phase = 0;
        ticks(12);
        ready = 1'b0;
        push(6, 6, Duty ? 3 : 0, 1'b1, 1'b0, 100);
        pulse_start();
        k = 0;
        while (!valid && k < 60) begin
            tick();
            k++;
        end
        check("bp_valid_seen", valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid_held", valid, 1);
            check("bp_period_held", period, 6);
            tick();
            start = (i == 5);
        end
        // Accept, with start held across the DONE->IDLE cycle: must be ignored.
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("bp_valid_drop", valid, 0);
        check("bp_busy_drop", busy, 0);
        ticks(3);
        check("bp_start_ignored", busy, 0);
        check("bp_drained", sb_q.size(), 0);

        // Timeout with sig stuck low.
        mode = 0;
        lvl  = 1'b0;
        ticks(5);
        push(255, 255, 0, 1'b0, 1'b1, 200);
        pulse_start();
        k = 0;
        while (!valid && k < 400) begin
            tick();
            k++;
        end
        n_vec++;
        if (k < 250 || k > 262) begin
            n_err++;
            $display("FAIL arm_timeout_latency: got %0d cycles, required about 255", k);
        end
        wait_drain(10, 200);

        // One rise, then stuck high: MEASURE saturates.
        ticks(3);
        push(255, 255, Duty ? 255 : 0, 1'b1, 1'b1, 201);
        pulse_start();
        ticks(5);
        lvl = 1'b1;
        wait_drain(400, 201);
        lvl = 1'b0;
        ticks(5);

        // Reset during MEASURE, N = 10.
        mode  = 1;
        div_n = 10;
        phase = 0;
        ticks(25);
        k = 0;
        while (phase != 6 && k < 20) begin
            tick();
            k++;
        end
        pulse_start();
        ticks(8);
        check("mid_busy_before_rst", busy, 1);
        check("mid_valid_before_rst", valid, 0);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        @(negedge clk);
        check("mid_busy_after_rst", busy, 0);
        check("mid_valid_after_rst", valid, 0);
        ticks(20);
        check("mid_no_valid", valid, 0);
        push(10, 10, Duty ? 5 : 0, 1'b1, 1'b0, 300);
        pulse_start();
        wait_drain(60, 300);

        // Asynchronous source: 73.3 ns against 10 ns.
        mode = 2;
        ticks(20);
        for (int i = 0; i < 50; i++) begin
            push(7, 8, 0, 1'b0, 1'b0, 400 + i);
            pulse_start();
            wait_drain(60, 400 + i);
        end
        mode = 0;
        ticks(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
